// File: rtl/ddr_clk_dly_cal.sv
`default_nettype none
// ============================================================================
// ddr_clk_dly_cal : IODELAY eye-centering controller (sweep, find window, park)
// Rev 1.0
// ============================================================================
module ddr_clk_dly_cal #(
    parameter int NTAPS   = 64,
    parameter int SETTLE  = 16,
    parameter int DWELL   = 256,
    parameter int MIN_WIN = 4,
    parameter int TW      = 6
) (
    input  logic          psClk,
    input  logic          psRst,
    input  logic          start,
    input  logic          patOk,
    output logic          dlyEna,
    output logic          dlyInc,
    output logic          dlyRst,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [TW-1:0] curTap,
    output logic [TW-1:0] winStart,
    output logic [TW:0]   winLen
);

    localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] c_lastTap   = TW'(NTAPS - 1);
    localparam logic [CW-1:0] c_settleEnd = CW'(SETTLE - 1);
    localparam logic [CW-1:0] c_dwellEnd  = CW'(DWELL - 1);
    localparam logic [TW:0]   c_minWin    = (TW + 1)'(MIN_WIN);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RST    = 4'd1,
        S_SETTLE = 4'd2,
        S_DWELL  = 4'd3,
        S_STEP   = 4'd4,
        S_EVAL   = 4'd5,
        S_RST2   = 4'd6,
        S_SEEK   = 4'd7,
        S_HOLD   = 4'd8,
        S_DONE   = 4'd9,
        S_FAIL   = 4'd10
    } state_t;

    state_t        r_state, w_state;
    logic          r_okMeta, r_okS;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_tapPass, w_tapPass;
    logic [TW-1:0] r_runStart, w_runStart, r_bestStart, w_bestStart;
    logic [TW:0]   r_runLen, w_runLen, r_bestLen, w_bestLen;
    logic [TW-1:0] r_target, w_target;
    logic          r_dlyEna, w_dlyEna, r_dlyRst, w_dlyRst;
    logic          r_busy, w_busy, r_done, w_done, r_fail, w_fail;
    logic [TW-1:0] r_curTap, w_curTap, r_winStart, w_winStart;
    logic [TW:0]   r_winLen, w_winLen;
    logic [TW:0]   w_evalLen;
    logic [TW-1:0] w_evalStart;

    // Run update applied in EVAL: extend on a passing tap, restart on a failing one.
    assign w_evalLen   = r_tapPass ? (r_runLen + 1'b1) : '0;
    assign w_evalStart = (r_tapPass && (r_runLen == '0)) ? r_curTap : r_runStart;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_tapPass   = r_tapPass;
        w_runStart  = r_runStart;
        w_runLen    = r_runLen;
        w_bestStart = r_bestStart;
        w_bestLen   = r_bestLen;
        w_target    = r_target;
        w_dlyEna    = 1'b0;
        w_dlyRst    = 1'b0;
        w_done      = r_done;
        w_fail      = r_fail;
        w_curTap    = r_curTap;
        w_winStart  = r_winStart;
        w_winLen    = r_winLen;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_state     = S_RST;
                    w_dlyRst    = 1'b1;
                    w_curTap    = '0;
                    w_cnt       = '0;
                    w_done      = 1'b0;
                    w_fail      = 1'b0;
                    w_winStart  = '0;
                    w_winLen    = '0;
                    w_runStart  = '0;
                    w_runLen    = '0;
                    w_bestStart = '0;
                    w_bestLen   = '0;
                end
            end
            S_RST: begin
                w_state = S_SETTLE;
                w_cnt   = '0;
            end
            S_SETTLE: begin
                if (r_cnt == c_settleEnd) begin
                    w_state   = S_DWELL;
                    w_cnt     = '0;
                    w_tapPass = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DWELL: begin
                w_tapPass = r_tapPass & r_okS;
                if (r_cnt == c_dwellEnd) begin
                    w_state = S_EVAL;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_EVAL: begin
                w_runLen   = w_evalLen;
                w_runStart = w_evalStart;
                // Strictly greater: on a tie the earlier (lower-start) window is kept.
                if (w_evalLen > r_bestLen) begin
                    w_bestLen   = w_evalLen;
                    w_bestStart = w_evalStart;
                end
                if (r_curTap == c_lastTap) begin
                    w_state  = S_RST2;
                    w_dlyRst = 1'b1;
                    w_curTap = '0;
                end else begin
                    w_state  = S_STEP;
                    w_dlyEna = 1'b1;
                    w_curTap = r_curTap + 1'b1;
                end
            end
            S_STEP: begin
                w_state = S_SETTLE;
                w_cnt   = '0;
            end
            S_RST2: begin
                w_winStart = r_bestStart;
                w_winLen   = r_bestLen;
                if (r_bestLen < c_minWin) begin
                    w_state = S_FAIL;
                    w_fail  = 1'b1;
                end else begin
                    w_state  = S_SEEK;
                    w_target = r_bestStart + TW'((r_bestLen - 1'b1) >> 1);
                end
            end
            S_SEEK: begin
                if (r_curTap == r_target) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_state  = S_HOLD;
                    w_dlyEna = 1'b1;
                    w_curTap = r_curTap + 1'b1;
                    w_cnt    = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == c_settleEnd) begin
                    w_state = S_SEEK;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy = !(w_state inside {S_IDLE, S_DONE, S_FAIL});
    end

    always_ff @(posedge psClk) begin
        if (psRst) begin
            r_state     <= S_IDLE;
            r_okMeta    <= 1'b0;
            r_okS       <= 1'b0;
            r_cnt       <= '0;
            r_tapPass   <= 1'b0;
            r_runStart  <= '0;
            r_runLen    <= '0;
            r_bestStart <= '0;
            r_bestLen   <= '0;
            r_target    <= '0;
            r_dlyEna    <= 1'b0;
            // Forces the IODELAY back to tap 0 so it agrees with curTap.
            r_dlyRst    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_curTap    <= '0;
            r_winStart  <= '0;
            r_winLen    <= '0;
        end else begin
            r_state     <= w_state;
            r_okMeta    <= patOk;
            r_okS       <= r_okMeta;
            r_cnt       <= w_cnt;
            r_tapPass   <= w_tapPass;
            r_runStart  <= w_runStart;
            r_runLen    <= w_runLen;
            r_bestStart <= w_bestStart;
            r_bestLen   <= w_bestLen;
            r_target    <= w_target;
            r_dlyEna    <= w_dlyEna;
            r_dlyRst    <= w_dlyRst;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_fail      <= w_fail;
            r_curTap    <= w_curTap;
            r_winStart  <= w_winStart;
            r_winLen    <= w_winLen;
        end
    end

    assign dlyEna   = r_dlyEna;
    assign dlyInc   = r_dlyEna;
    assign dlyRst   = r_dlyRst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;
    assign curTap   = r_curTap;
    assign winStart = r_winStart;
    assign winLen   = r_winLen;

endmodule
`default_nettype wire
